io_ring_pwr_seq: RTL and testbench
==================================

# io_ring_pwr_seq

Power-up and power-down sequencer for the GF22 1.8 V IO ring. It sits directly beside the ring's VSSX/VDDX/VDDIO supply pads on the core side. It consumes the asynchronous power-good flags from the ring's supply detectors and drives the pad-wide retention, input-enable and output-enable controls. Core logic never sees pads toggling while ring supplies are ramping or collapsing.

## Interface
Parameters:
- CNT_W, 16: width of the shared delay counter.
- DEB_CYCLES, 16: cycles both power-good flags must stay high before sequencing starts (1..2^CNT_W-1).
- IE_DELAY, 4: cycles between input-enable assertion and retention release (≥1).
- OE_DELAY, 8: cycles between retention release and output-enable assertion; also the shutdown hold time (≥1).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- pg_vddio_i  in  1  VDDIO power-good, asynchronous.
- pg_vddx_i  in  1  VDDX power-good, asynchronous.
- sw_off_i  in  1  software power-down request, level, synchronous to clk.
- pad_ret_o  out  1  pad retention, 1 = pads frozen.
- pad_ie_o  out  1  pad input-receiver enable.
- pad_oe_en_o  out  1  global pad output-enable gate.
- io_ready_o  out  1  ring fully operational.
- state_o  out  3  current FSM state code.
- fault_cnt_o  out  8  saturating fault count. Present only with IO_SEQ_FAULT_CNT_EN.

## Operation
- The clock is clk and the reset is rst. There is one clock. Reset is asynchronous and active-high.
- Reset values: pad_ret_o=1, pad_ie_o=0, pad_oe_en_o=0, io_ready_o=0, state_o=OFF(0), fault_cnt_o=0, counter=0.
- Each pg input passes through its own 2-flop synchronizer. pg_ok is the AND of both synchronized flags.
- FSM states and codes: OFF=0, DEBOUNCE=1, IE_ON=2, RET_OFF=3, READY=4, SHUTDOWN=5.
- OFF: enter DEBOUNCE when pg_ok=1 and sw_off_i=0. Load counter=0.
- DEBOUNCE: counter increments each cycle. If pg_ok drops, return to OFF with no fault counted. When the counter reaches DEB_CYCLES-1, go to IE_ON.
- IE_ON: lasts IE_DELAY cycles, then RET_OFF.
- RET_OFF: lasts OE_DELAY cycles, then READY.
- READY: stay while pg_ok=1 and sw_off_i=0. sw_off_i=1 moves to SHUTDOWN.
- SHUTDOWN: lasts OE_DELAY cycles, then OFF. OFF stays OFF while sw_off_i=1.
- Outputs are registered decodes of the next state:
  - pad_ie_o=1 in IE_ON, RET_OFF, READY, SHUTDOWN.
  - pad_ret_o=0 in RET_OFF and READY only.
  - pad_oe_en_o=1 and io_ready_o=1 in READY only.
- Fault: pg_ok=0 while in IE_ON, RET_OFF, READY or SHUTDOWN forces OFF on the next edge.
  - All pad controls return to reset values in that same cycle.
  - The fault event is counted.
  - A fault has priority over sw_off_i and over any delay expiry in the same cycle.
- sw_off_i during DEBOUNCE, IE_ON or RET_OFF aborts to OFF. This is not a fault.
- The counter clears on every state change and never wraps. It is compared only against its state's terminal value.

## Timing
- Both pg inputs are high at edge 0 and sw_off_i=0. Then:
  - pad_ie_o rises at edge 3+DEB_CYCLES.
  - pad_ret_o falls IE_DELAY cycles later.
  - pad_oe_en_o and io_ready_o rise OE_DELAY cycles after that.
- Fault response: pad_oe_en_o falls and pad_ret_o rises 3 edges after the raw pg falls (2 sync + 1 register).
- Shutdown: pad_oe_en_o and io_ready_o fall 1 edge after sw_off_i is seen.
  - pad_ret_o rises on that same edge.
  - pad_ie_o falls OE_DELAY cycles later.
- Reset asserted mid-sequence forces reset values immediately, asynchronously. Release resumes from OFF.

## Configuration
- IO_SEQ_FAULT_CNT_EN defined:
  - fault_cnt_o exists as an 8-bit counter.
  - It increments on each fault event and saturates at 255.
  - It is cleared only by rst.
- IO_SEQ_FAULT_CNT_EN undefined: the port and the counter logic are absent. FSM behaviour is identical in both cases.

## Test plan
- Power-up with defaults: both pg high at edge 0. Expect pad_ie_o=1 at edge 19, pad_ret_o=0 at edge 23, pad_oe_en_o=io_ready_o=1 at edge 31, state_o=4.
- Debounce glitch: pg_vddx_i low for 1 cycle at edge 10 of DEBOUNCE. Expect return to OFF, pad_ie_o stays 0, fault_cnt_o unchanged, and the sequence restarts cleanly.
- Brown-out in READY: drop pg_vddio_i. Expect pad_oe_en_o=0, pad_ret_o=1, pad_ie_o=0 3 edges later, state_o=0, fault_cnt_o increments by 1.
- Software off: assert sw_off_i in READY. Expect pad_oe_en_o=0 and pad_ret_o=1 after 1 edge, pad_ie_o=0 8 cycles later, state held at OFF until sw_off_i=0.
- Simultaneous events: pg drop and sw_off_i=1 at the same edge in READY. Expect fault path (fault_cnt_o+1), not SHUTDOWN. Separately, 300 forced faults: expect fault_cnt_o saturates at 255.
- Async reset asserted in RET_OFF mid-count: expect all outputs at reset values before the next clk edge, then a normal power-up after release.

Source files
------------

// File: rtl/io_ring_pwr_seq.sv
// Power-up/power-down sequencer for the 1.8 V IO ring pad controls.
// Optional saturating fault counter enabled by defining IO_SEQ_FAULT_CNT_EN.
module io_ring_pwr_seq #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned IE_DELAY   = 4,
    parameter int unsigned OE_DELAY   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pg_vddio_i,
    input  logic       pg_vddx_i,
    input  logic       sw_off_i,
    output logic       pad_ret_o,
    output logic       pad_ie_o,
    output logic       pad_oe_en_o,
    output logic       io_ready_o,
    output logic [2:0] state_o
`ifdef IO_SEQ_FAULT_CNT_EN
    ,
    output logic [7:0] fault_cnt_o
`endif
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StDebounce = 3'd1,
        StIeOn     = 3'd2,
        StRetOff   = 3'd3,
        StReady    = 3'd4,
        StShutdown = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vddio_sync_q, vddx_sync_q;
    logic             pg_ok;
    logic             ret_q, ret_d, ie_q, ie_d, oe_q, oe_d;

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] IeLast  = CNT_W'(IE_DELAY - 1);
    localparam logic [CNT_W-1:0] OeLast  = CNT_W'(OE_DELAY - 1);

    assign pg_ok = vddio_sync_q[1] & vddx_sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Loss of supply is checked first so it wins over sw_off_i and delay expiry.
        unique case (state_q)
            StOff: begin
                cnt_d = '0;
                if (pg_ok && !sw_off_i) state_d = StDebounce;
            end
            StDebounce: begin
                if (!pg_ok || sw_off_i) state_d = StOff;
                else if (cnt_q == DebLast) state_d = StIeOn;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            StIeOn: begin
                if (!pg_ok || sw_off_i) state_d = StOff;
                else if (cnt_q == IeLast) state_d = StRetOff;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            StRetOff: begin
                if (!pg_ok || sw_off_i) state_d = StOff;
                else if (cnt_q == OeLast) state_d = StReady;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            StReady: begin
                if (!pg_ok) state_d = StOff;
                else if (sw_off_i) state_d = StShutdown;
            end
            StShutdown: begin
                if (!pg_ok || cnt_q == OeLast) state_d = StOff;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = StOff;
        endcase
        if (state_d != state_q) cnt_d = '0;

        ie_d  = (state_d == StIeOn) || (state_d == StRetOff) ||
                (state_d == StReady) || (state_d == StShutdown);
        ret_d = !((state_d == StRetOff) || (state_d == StReady));
        oe_d  = (state_d == StReady);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            vddio_sync_q <= 2'b00;
            vddx_sync_q  <= 2'b00;
            ret_q        <= 1'b1;
            ie_q         <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vddio_sync_q <= {vddio_sync_q[0], pg_vddio_i};
            vddx_sync_q  <= {vddx_sync_q[0], pg_vddx_i};
            ret_q        <= ret_d;
            ie_q         <= ie_d;
            oe_q         <= oe_d;
        end
    end

    assign pad_ret_o   = ret_q;
    assign pad_ie_o    = ie_q;
    assign pad_oe_en_o = oe_q;
    assign io_ready_o  = oe_q;
    assign state_o     = state_q;

`ifdef IO_SEQ_FAULT_CNT_EN
    logic       fault;
    logic [7:0] fault_cnt_q;

    // Aborts during debounce are not faults; only loss of supply once pads are live.
    assign fault = !pg_ok && ((state_q == StIeOn) || (state_q == StRetOff) ||
                              (state_q == StReady) || (state_q == StShutdown));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt_q <= 8'd0;
        end else if (fault && (fault_cnt_q != 8'hff)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end

    assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Self-checking bench for io_ring_pwr_seq against a phase/elapsed-time model.
// Fault counter checks are active when IO_SEQ_FAULT_CNT_EN is defined.
module tb_io_ring_pwr_seq;

    localparam int DEB  = 16;
    localparam int IED  = 4;
    localparam int OED  = 8;
    localparam int UP_T = DEB + IED + OED;

    logic       clk = 1'b0;
    logic       rst, pg_vddio, pg_vddx, sw_off;
    logic       pad_ret, pad_ie, pad_oe, io_ready;
    logic [2:0] state;
`ifdef IO_SEQ_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    io_ring_pwr_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pg_vddio_i  (pg_vddio),
        .pg_vddx_i   (pg_vddx),
        .sw_off_i    (sw_off),
        .pad_ret_o   (pad_ret),
        .pad_ie_o    (pad_ie),
        .pad_oe_en_o (pad_oe),
        .io_ready_o  (io_ready),
        .state_o     (state)
`ifdef IO_SEQ_FAULT_CNT_EN
        ,
        .fault_cnt_o (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = off, 1 = powering/powered up (e cycles since debounce start),
    // 2 = shutting down (d cycles into shutdown).
    bit [1:0] m_sa, m_sb;
    int       m_mode, m_e, m_d, m_faults;

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 5;
        if (m_e < DEB) return 1;
        if (m_e < DEB + IED) return 2;
        if (m_e < UP_T) return 3;
        return 4;
    endfunction

    function automatic bit exp_ie();
        return (m_mode == 2) || (m_mode == 1 && m_e >= DEB);
    endfunction

    function automatic bit exp_ret();
        return !(m_mode == 1 && m_e >= DEB + IED);
    endfunction

    function automatic bit exp_oe();
        return (m_mode == 1 && m_e >= UP_T);
    endfunction

    task automatic model_reset();
        m_sa = 2'b00; m_sb = 2'b00; m_mode = 0; m_e = 0; m_d = 0; m_faults = 0;
    endtask

    task automatic model_fault();
        m_mode = 0;
        if (m_faults < 255) m_faults++;
    endtask

    task automatic model_step();
        bit ok;
        ok   = m_sa[1] & m_sb[1];
        m_sa = {m_sa[0], pg_vddio};
        m_sb = {m_sb[0], pg_vddx};
        case (m_mode)
            0: if (ok && !sw_off) begin m_mode = 1; m_e = 0; end
            1: begin
                if (!ok && m_e >= DEB) model_fault();
                else if (!ok || (sw_off && m_e < UP_T)) m_mode = 0;
                else if (sw_off) begin m_mode = 2; m_d = 0; end
                else if (m_e < UP_T) m_e++;
            end
            default: begin
                if (!ok) model_fault();
                else begin
                    m_d++;
                    if (m_d >= OED) m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pg_vddio = 1'b0; pg_vddx = 1'b0; sw_off = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if ({pad_ret, pad_ie, pad_oe, io_ready} !== 4'b1000) begin
            bad++; $display("FAIL rst_pads got=%b want=1000", {pad_ret, pad_ie, pad_oe, io_ready});
        end
`ifdef IO_SEQ_FAULT_CNT_EN
        total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL rst_fcnt got=%0d want=0", fault_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_power_up();
        tick();  // edge 0
        pg_vddio = 1'b1; pg_vddx = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            total++; if (state !== 3'(exp_state())) begin
                bad++; $display("FAIL pu_state e%0d got=%0d want=%0d", i, state, exp_state());
            end
            if (i == 18) begin
                total++; if (pad_ie !== 1'b0) begin bad++; $display("FAIL pu_ie18 got=%b want=0", pad_ie); end
            end
            if (i == 19) begin
                total++; if (pad_ie !== 1'b1) begin bad++; $display("FAIL pu_ie19 got=%b want=1", pad_ie); end
            end
            if (i == 22) begin
                total++; if (pad_ret !== 1'b1) begin bad++; $display("FAIL pu_ret22 got=%b want=1", pad_ret); end
            end
            if (i == 23) begin
                total++; if (pad_ret !== 1'b0) begin bad++; $display("FAIL pu_ret23 got=%b want=0", pad_ret); end
            end
            if (i == 30) begin
                total++; if (pad_oe !== 1'b0) begin bad++; $display("FAIL pu_oe30 got=%b want=0", pad_oe); end
            end
        end
        total++; if ({pad_oe, io_ready, state} !== {2'b11, 3'd4}) begin
            bad++; $display("FAIL pu_ready31 got=%b%b/%0d want=11/4", pad_oe, io_ready, state);
        end
    endtask

    task automatic test_sw_off();
        sw_off = 1'b1;
        tick();
        total++; if ({pad_oe, io_ready, pad_ret, pad_ie, state} !== {4'b0011, 3'd5}) begin
            bad++; $display("FAIL swoff_1 got=%b%b%b%b/%0d want=0011/5", pad_oe, io_ready, pad_ret, pad_ie, state);
        end
        repeat (7) tick();
        total++; if (pad_ie !== 1'b1) begin bad++; $display("FAIL swoff_ie7 got=%b want=1", pad_ie); end
        tick();
        total++; if ({pad_ie, state} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL swoff_ie8 got=%b/%0d want=0/0", pad_ie, state);
        end
        repeat (20) tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL swoff_hold got=%0d want=0", state); end
        sw_off = 1'b0;
        repeat (31) tick();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL swoff_restart got=%0d want=4", state); end
    endtask

    task automatic test_brownout();
        int f0 = m_faults;
        pg_vddio = 1'b0;
        repeat (2) tick();
        total++; if (pad_oe !== 1'b1) begin bad++; $display("FAIL bo_oe2 got=%b want=1", pad_oe); end
        tick();
        total++; if ({pad_oe, pad_ret, pad_ie, state} !== {3'b010, 3'd0}) begin
            bad++; $display("FAIL bo_pads got=%b%b%b/%0d want=010/0", pad_oe, pad_ret, pad_ie, state);
        end
        total++; if (m_faults !== f0 + 1) begin
            bad++; $display("FAIL bo_model_fault got=%0d want=%0d", m_faults, f0 + 1);
        end
`ifdef IO_SEQ_FAULT_CNT_EN
        total++; if (fault_cnt !== 8'(f0 + 1)) begin
            bad++; $display("FAIL bo_fcnt got=%0d want=%0d", fault_cnt, f0 + 1);
        end
`endif
    endtask

    task automatic test_debounce_glitch();
        int f0 = m_faults;
        pg_vddio = 1'b1;
        repeat (3) tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL gl_deb got=%0d want=1", state); end
        repeat (10) tick();
        pg_vddx = 1'b0;
        tick();
        pg_vddx = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick();
            total++; if ({pad_ie, state} !== {exp_ie(), 3'(exp_state())}) begin
                bad++; $display("FAIL gl_step%0d got=%b/%0d want=%b/%0d", i, pad_ie, state, exp_ie(), exp_state());
            end
        end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL gl_final got=%0d want=4", state); end
`ifdef IO_SEQ_FAULT_CNT_EN
        total++; if (fault_cnt !== 8'(f0)) begin bad++; $display("FAIL gl_fcnt got=%0d want=%0d", fault_cnt, f0); end
`else
        total++; if (m_faults !== f0) begin bad++; $display("FAIL gl_model_fault got=%0d want=%0d", m_faults, f0); end
`endif
    endtask

    task automatic test_simultaneous();
        int f0 = m_faults;
        pg_vddx = 1'b0;
        repeat (2) tick();
        sw_off = 1'b1;
        tick();
        total++; if ({pad_ret, pad_ie, pad_oe, state} !== {3'b100, 3'd0}) begin
            bad++; $display("FAIL sim_state got=%b%b%b/%0d want=100/0", pad_ret, pad_ie, pad_oe, state);
        end
`ifdef IO_SEQ_FAULT_CNT_EN
        total++; if (fault_cnt !== 8'(f0 + 1)) begin
            bad++; $display("FAIL sim_fcnt got=%0d want=%0d", fault_cnt, f0 + 1);
        end
`else
        total++; if (m_faults !== f0 + 1) begin bad++; $display("FAIL sim_model got=%0d want=%0d", m_faults, f0 + 1); end
`endif
    endtask

    task automatic test_async_reset();
        sw_off = 1'b0; pg_vddx = 1'b1; pg_vddio = 1'b1;
        repeat (26) tick();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL ar_retoff got=%0d want=3", state); end
        #3 rst = 1'b1;
        #1;
        total++; if ({pad_ret, pad_ie, pad_oe, io_ready, state} !== {4'b1000, 3'd0}) begin
            bad++; $display("FAIL ar_async got=%b%b%b%b/%0d want=1000/0", pad_ret, pad_ie, pad_oe, io_ready, state);
        end
`ifdef IO_SEQ_FAULT_CNT_EN
        total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL ar_fcnt got=%0d want=0", fault_cnt); end
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (32) tick();
        total++; if ({pad_oe, io_ready, state} !== {2'b11, 3'd4}) begin
            bad++; $display("FAIL ar_restart got=%b%b/%0d want=11/4", pad_oe, io_ready, state);
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 300; n++) begin
            pg_vddio = 1'b1; pg_vddx = 1'b1;
            repeat (22) tick();
            pg_vddio = 1'b0; pg_vddx = 1'b0;
            repeat (4) tick();
        end
        total++; if (m_faults !== 255) begin bad++; $display("FAIL sat_model got=%0d want=255", m_faults); end
`ifdef IO_SEQ_FAULT_CNT_EN
        total++; if (fault_cnt !== 8'd255) begin bad++; $display("FAIL sat_fcnt got=%0d want=255", fault_cnt); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) pg_vddio = ~pg_vddio;
            if ($urandom_range(0, 39) == 0) pg_vddx = ~pg_vddx;
            if ($urandom_range(0, 59) == 0) sw_off = ~sw_off;
            tick();
            total++; if ({state, pad_ret, pad_ie, pad_oe, io_ready} !==
                         {3'(exp_state()), exp_ret(), exp_ie(), exp_oe(), exp_oe()}) begin
                bad++; $display("FAIL rnd%0d got=%0d/%b%b%b%b want=%0d/%b%b%b%b", i, state, pad_ret,
                                pad_ie, pad_oe, io_ready, exp_state(), exp_ret(), exp_ie(),
                                exp_oe(), exp_oe());
            end
`ifdef IO_SEQ_FAULT_CNT_EN
            total++; if (fault_cnt !== 8'(m_faults)) begin
                bad++; $display("FAIL rnd_fcnt%0d got=%0d want=%0d", i, fault_cnt, m_faults);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_off();
        test_brownout();
        test_debounce_glitch();
        test_simultaneous();
        test_async_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
